// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package if_pkg;

    localparam int unsigned IF_ADDR_W   = 8;
    localparam int unsigned IF_DATA_W   = 32;
    localparam int unsigned IF_RESET_PC = 0;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } if_state_e;

    typedef struct packed {
        logic                 valid;
        logic [IF_ADDR_W-1:0] pc;
        logic [IF_DATA_W-1:0] instr;
    } if_bundle_t;

endpackage

// File: rtl/if_skid_buf.sv
// One-entry skid register: capture holds a fetched word while decode stalls, clear empties it.
module if_skid_buf
    import if_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       capture_i,
    input  logic       clear_i,
    input  if_bundle_t data_i,
    output if_bundle_t q_o
);

    if_bundle_t skid_q, skid_d;

    // Clear wins over capture so a redirect always empties the entry.
    always_comb begin
        skid_d = skid_q;
        if (clear_i) begin
            skid_d = '0;
        end else if (capture_i) begin
            skid_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_q <= '0;
        end else begin
            skid_q <= skid_d;
        end
    end

    assign q_o = skid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, memory address, word tagging, skid-buffered IF/ID bundle.
// Optional performance counters are built when IF_PERF_EN is defined. ADDR_W/DATA_W must match if_pkg.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int unsigned ADDR_W   = IF_ADDR_W,
    parameter int unsigned DATA_W   = IF_DATA_W,
    parameter int unsigned RESET_PC = IF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [31:0]       imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [DATA_W-1:0] id_instr_o,
    output logic [31:0]       fetch_cnt_o,
    output logic [31:0]       flush_cnt_o
);

    if_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] f_pc_q, f_pc_d;
    logic              f_valid_q, f_valid_d;
    if_bundle_t        id_q, id_d;
    if_bundle_t        skid_q, skid_in;
    logic              skid_capture, skid_clear;
    logic              fetch_inc;
    logic [1:0]        flush_add;

    assign skid_in = '{valid: 1'b1, pc: f_pc_q, instr: imem_data_i};

    if_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture_i (skid_capture),
        .clear_i   (skid_clear),
        .data_i    (skid_in),
        .q_o       (skid_q)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        f_pc_d       = f_pc_q;
        f_valid_d    = f_valid_q;
        id_d         = id_q;
        skid_capture = 1'b0;
        skid_clear   = 1'b0;
        fetch_inc    = 1'b0;
        flush_add    = 2'd0;
        if (redirect_i) begin
            pc_d       = redirect_pc_i;
            f_valid_d  = 1'b0;
            skid_clear = 1'b1;
            id_d.valid = 1'b0;
            state_d    = ST_RUN;
            flush_add  = 2'(f_valid_q) + 2'(skid_q.valid) + 2'(id_q.valid);
        end else begin
            unique case (state_q)
                ST_RUN: begin
                    if (stall_i) begin
                        // Word arriving this cycle would be lost; park it if it is real.
                        f_valid_d = 1'b0;
                        if (f_valid_q) begin
                            skid_capture = 1'b1;
                            state_d      = ST_HOLD;
                        end
                    end else begin
                        id_d      = '{valid: f_valid_q, pc: f_pc_q, instr: imem_data_i};
                        fetch_inc = f_valid_q;
                        f_pc_d    = pc_q;
                        f_valid_d = 1'b1;
                        pc_d      = pc_q + ADDR_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (!stall_i) begin
                        id_d       = skid_q;
                        fetch_inc  = skid_q.valid;
                        skid_clear = 1'b1;
                        f_pc_d     = pc_q;
                        f_valid_d  = 1'b1;
                        pc_d       = pc_q + ADDR_W'(1);
                        state_d    = ST_RUN;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            pc_q      <= ADDR_W'(RESET_PC);
            f_pc_q    <= '0;
            f_valid_q <= 1'b0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            f_pc_q    <= f_pc_d;
            f_valid_q <= f_valid_d;
            id_q      <= id_d;
        end
    end

    assign imem_addr_o = 32'(pc_q);
    assign id_valid_o  = id_q.valid;
    assign id_pc_o     = id_q.pc;
    assign id_instr_o  = id_q.instr;

`ifdef IF_PERF_EN
    logic [31:0] fetch_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (fetch_inc) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            flush_cnt_q <= flush_cnt_q + 32'(flush_add);
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf = ^{fetch_inc, flush_add};
    assign fetch_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage against a program-order scoreboard of expected PCs.
module tb_if_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic        id_valid;
    logic [7:0]  id_pc;
    logic [31:0] id_instr;
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;

    logic [31:0] mem [256];

    int unsigned n_vec;
    int unsigned n_err;
    logic [7:0]  exp_pc;
    int unsigned delivered;
    int unsigned streak;
    logic [31:0] f0;

    if_fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr_o   (imem_addr),
        .imem_data_i   (imem_data),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .id_valid_o    (id_valid),
        .id_pc_o       (id_pc),
        .id_instr_o    (id_instr),
        .fetch_cnt_o   (fetch_cnt),
        .flush_cnt_o   (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr[7:0]];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock with the given controls, then score the IF/ID bundle against program order.
    task automatic step(input logic st, input logic rd, input logic [7:0] tgt);
        logic        pv;
        logic [7:0]  ppc;
        logic [31:0] pin;
        pv  = id_valid;
        ppc = id_pc;
        pin = id_instr;
        stall       = st;
        redirect    = rd;
        redirect_pc = tgt;
        @(posedge clk);
        @(negedge clk);
        if (rd) begin
            check_eq("redir_kill", 32'(id_valid), 32'd0);
            exp_pc = tgt;
            streak = 0;
        end else if (st) begin
            check_eq("hold_valid", 32'(id_valid), 32'(pv));
            check_eq("hold_pc", 32'(id_pc), 32'(ppc));
            check_eq("hold_instr", id_instr, pin);
        end else if (id_valid) begin
            check_eq("order_pc", 32'(id_pc), 32'(exp_pc));
            check_eq("order_instr", id_instr, mem[exp_pc]);
            exp_pc = exp_pc + 8'd1;
            delivered++;
            streak = 0;
        end else begin
            streak++;
            check_eq("bubble_bound", 32'(streak <= 1), 32'd1);
        end
        check_eq("addr_range", 32'(imem_addr[31:8]), 32'd0);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[0] = 32'h00813002;
        mem[1] = 32'h00834001;
        mem[2] = 32'h00834001;

        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(id_valid), 32'd0);
        check_eq("rst_pc", 32'(id_pc), 32'd0);
        check_eq("rst_instr", id_instr, 32'd0);
        check_eq("rst_addr", imem_addr, 32'd0);
        check_eq("rst_fetch_cnt", fetch_cnt, 32'd0);
        check_eq("rst_flush_cnt", flush_cnt, 32'd0);

        rst_n = 1'b1;
        exp_pc = 8'd0;
        streak = 0;
        delivered = 0;
        step(1'b0, 1'b0, 8'd0);
        check_eq("rel_e1_valid", 32'(id_valid), 32'd0);
        step(1'b0, 1'b0, 8'd0);
        check_eq("rel_e2_valid", 32'(id_valid), 32'd1);
        check_eq("rel_e2_pc", 32'(id_pc), 32'd0);
        check_eq("rel_e2_instr", id_instr, 32'h00813002);
        step(1'b0, 1'b0, 8'd0);
        check_eq("rel_e3_pc", 32'(id_pc), 32'd1);
        check_eq("rel_e3_instr", id_instr, 32'h00834001);

        repeat (3) step(1'b1, 1'b0, 8'd0);
        check_eq("stall_frozen_pc", 32'(id_pc), 32'd1);
        step(1'b0, 1'b0, 8'd0);
        check_eq("unstall_valid", 32'(id_valid), 32'd1);
        check_eq("unstall_pc", 32'(id_pc), 32'd2);
        check_eq("unstall_instr", id_instr, 32'h00834001);
        step(1'b0, 1'b0, 8'd0);
        check_eq("unstall_next_pc", 32'(id_pc), 32'd3);

        f0 = flush_cnt;
        step(1'b0, 1'b1, 8'd5);
        step(1'b0, 1'b0, 8'd0);
        check_eq("redir_lo2", 32'(id_valid), 32'd0);
        step(1'b0, 1'b0, 8'd0);
        check_eq("redir_tgt_valid", 32'(id_valid), 32'd1);
        check_eq("redir_tgt_pc", 32'(id_pc), 32'd5);
        step(1'b0, 1'b0, 8'd0);
        check_eq("redir_tgt_next", 32'(id_pc), 32'd6);
`ifdef IF_PERF_EN
        check_eq("redir_flush_delta", flush_cnt - f0, 32'd2);
`endif

        step(1'b1, 1'b0, 8'd0);
        f0 = flush_cnt;
        step(1'b1, 1'b1, 8'd20);
        step(1'b1, 1'b0, 8'd0);
        for (int k = 0; k < 4 && !id_valid; k++) step(1'b0, 1'b0, 8'd0);
        check_eq("hold_redir_valid", 32'(id_valid), 32'd1);
        check_eq("hold_redir_pc", 32'(id_pc), 32'd20);
`ifdef IF_PERF_EN
        check_eq("hold_flush_delta", flush_cnt - f0, 32'd2);
`endif

        step(1'b0, 1'b1, 8'hFF);
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        check_eq("wrap_ff", 32'(id_pc), 32'hFF);
        step(1'b0, 1'b0, 8'd0);
        check_eq("wrap_00", 32'(id_pc), 32'h00);
        step(1'b0, 1'b0, 8'd0);
        check_eq("wrap_01", 32'(id_pc), 32'h01);

        step(1'b1, 1'b0, 8'd0);
        step(1'b1, 1'b0, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(id_valid), 32'd0);
        check_eq("async_rst_addr", imem_addr, 32'd0);
        check_eq("async_rst_fetch", fetch_cnt, 32'd0);
        stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 8'd0;
        streak = 0;
        delivered = 0;
        step(1'b0, 1'b0, 8'd0);
        step(1'b0, 1'b0, 8'd0);
        check_eq("refetch_valid", 32'(id_valid), 32'd1);
        check_eq("refetch_pc", 32'(id_pc), 32'd0);

        for (int n = 0; n < 1500; n++) begin
            step(1'($urandom_range(0, 99) < 30), 1'($urandom_range(0, 99) < 5),
                 8'($urandom_range(0, 255)));
        end

`ifdef IF_PERF_EN
        check_eq("fetch_cnt_total", fetch_cnt, 32'(delivered));
`else
        check_eq("fetch_cnt_off", fetch_cnt, 32'd0);
        check_eq("flush_cnt_off", flush_cnt, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
